ro_meas_seq: RTL and testbench

- Measurement sequencer directly downstream of the ring-oscillator counter stage, in the `clk` domain.
- Drives the counter's `enable` for a fixed gate window of `clk` cycles, then waits for the frozen count to settle and captures it.
- The upstream counter is never cleared between windows, so each window is computed as a modulo-2^CNT_W difference from the previous capture.
- Averages 2^AVG_LOG2 windows and presents one result with a valid pulse.

---
 rtl/ro_meas_seq.sv | 197 +++++++++++++++++++
 tb/tb_ro_meas_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_meas_seq.sv
// Ring-oscillator measurement sequencer. It gates the upstream counter for a fixed
// window, captures the settled count as a wrapping delta and averages 2**AVG_LOG2 windows.
module ro_meas_seq #(
  parameter int CNT_W         = 15,
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 4,
  parameter int AVG_LOG2      = 2,
  parameter int CAP_TRIES     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic [CNT_W-1:0] cnt_in,
  output logic             ro_enable,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             capture_err
);

  localparam int SUM_W   = CNT_W + AVG_LOG2;
  localparam int WIN_W   = AVG_LOG2 + 1;
  localparam int GS_MAX  = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_MAX = (GS_MAX > CAP_TRIES) ? GS_MAX : CAP_TRIES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TRIES_LAST  = TMR_W'(CAP_TRIES - 1);
  localparam logic [WIN_W-1:0] WIN_FULL    = WIN_W'(1 << AVG_LOG2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BSETTLE,
    S_BCAP,
    S_GATE,
    S_SETTLE,
    S_CAP,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] s1_q;
  logic [CNT_W-1:0] s2_q;
  logic [CNT_W-1:0] prev_q;
  logic [CNT_W-1:0] result_q;
  logic [SUM_W-1:0] sum_q;
  logic [WIN_W-1:0] win_q;
  logic [TMR_W-1:0] timer_q;
  logic             ro_enable_q;
  logic             busy_q;
  logic             result_valid_q;
  logic             capture_err_q;

  logic             cap_stable;
  logic             cap_accept;
  logic [CNT_W-1:0] delta_d;
  logic [SUM_W-1:0] sum_d;
  logic [WIN_W-1:0] win_d;
  logic [TMR_W-1:0] timer_inc;

  // A capture is taken once two consecutive samples agree, or forced after
  // CAP_TRIES disagreeing cycles (timer_q counts the attempts).
  assign cap_stable = (s1_q == s2_q);
  assign cap_accept = cap_stable || (timer_q == TRIES_LAST);

  // The counter is never cleared, so the window delta wraps modulo 2**CNT_W;
  // windows of 2**CNT_W or more oscillator edges alias silently.
  assign delta_d   = s2_q - prev_q;
  assign sum_d     = sum_q + SUM_W'(delta_d);
  assign win_d     = win_q + 1'b1;
  assign timer_inc = timer_q + 1'b1;

  // NOTE: every register here is assigned with non-blocking (<=) so all state
  // updates see pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      s1_q           <= '0;
      s2_q           <= '0;
      prev_q         <= '0;
      result_q       <= '0;
      sum_q          <= '0;
      win_q          <= '0;
      timer_q        <= '0;
      ro_enable_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      capture_err_q  <= 1'b0;
    end else begin
      s1_q           <= cnt_in;
      s2_q           <= s1_q;
      result_valid_q <= 1'b0;
      ro_enable_q    <= 1'b0;

      if (abort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              capture_err_q <= 1'b0;
              sum_q         <= '0;
              win_q         <= '0;
              timer_q       <= '0;
              busy_q        <= 1'b1;
              state_q       <= S_BSETTLE;
            end
          end

          S_BSETTLE: begin
            if (timer_q == SETTLE_LAST) begin
              timer_q <= '0;
              state_q <= S_BCAP;
            end else begin
              timer_q <= timer_inc;
            end
          end

          S_BCAP: begin
            if (cap_accept) begin
              if (!cap_stable) capture_err_q <= 1'b1;
              prev_q  <= s2_q;
              timer_q <= '0;
              state_q <= S_GATE;
            end else begin
              timer_q <= timer_inc;
            end
          end

          // ro_enable follows GATE one cycle late, giving exactly GATE_CYCLES high cycles.
          S_GATE: begin
            ro_enable_q <= 1'b1;
            if (timer_q == GATE_LAST) begin
              timer_q <= '0;
              state_q <= S_SETTLE;
            end else begin
              timer_q <= timer_inc;
            end
          end

          S_SETTLE: begin
            if (timer_q == SETTLE_LAST) begin
              timer_q <= '0;
              state_q <= S_CAP;
            end else begin
              timer_q <= timer_inc;
            end
          end

          S_CAP: begin
            if (cap_accept) begin
              if (!cap_stable) capture_err_q <= 1'b1;
              sum_q   <= sum_d;
              prev_q  <= s2_q;
              win_q   <= win_d;
              timer_q <= '0;
              state_q <= (win_d == WIN_FULL) ? S_DONE : S_GATE;
            end else begin
              timer_q <= timer_inc;
            end
          end

          S_DONE: begin
            result_q       <= CNT_W'(sum_q >> AVG_LOG2);
            result_valid_q <= 1'b1;
            if (continuous) begin
              // The last capture becomes the next baseline; no BSETTLE/BCAP pass.
              sum_q   <= '0;
              win_q   <= '0;
              timer_q <= '0;
              state_q <= S_GATE;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end

          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ro_enable    = ro_enable_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign capture_err  = capture_err_q;

endmodule

// File: tb/tb_ro_meas_seq.sv
// Bench for ro_meas_seq: a behavioural ring-oscillator counter feeds the sequencer and a
// window-level model predicts each averaged result from the counts the bench applied.
module tb_ro_meas_seq;

  localparam int CNT_W = 15;
  localparam int G     = 10;
  localparam int S     = 2;
  localparam int A     = 2;
  localparam int T     = 8;
  localparam int N     = 1 << A;
  localparam int LAT   = S + 2 + N * (G + S + 1);
  localparam int PERIOD = N * (G + S + 1) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             continuous;
  logic             abort;
  logic [CNT_W-1:0] cnt_in;
  logic             ro_enable;
  logic             busy;
  logic [CNT_W-1:0] result;
  logic             result_valid;
  logic             capture_err;

  int n_checks = 0;
  int n_fail   = 0;

  ro_meas_seq #(
    .CNT_W(CNT_W), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .AVG_LOG2(A), .CAP_TRIES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .abort(abort),
    .cnt_in(cnt_in), .ro_enable(ro_enable), .busy(busy), .result(result),
    .result_valid(result_valid), .capture_err(capture_err)
  );

  initial forever #5 clk = ~clk;

  // Upstream counter model: one count per clk while enabled, optional extra counts
  // at the first enabled cycle of a window, and an optional unstable capture phase.
  logic [CNT_W-1:0] cnt = '0;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] cap_arr [64];
  int               extra_tab [64];
  int               load_seq = 0;
  int               load_seen = 0;
  int               rise_cnt = 0;
  int               fall_cnt = 0;
  int               inst_fall = -1;
  int               inst_left = 0;
  int               ex;
  bit               was_hi = 1'b0;
  bit               mask = 1'b0;

  initial begin
    cnt_in = '0;
    for (int i = 0; i < 64; i++) extra_tab[i] = 0;
    forever begin
      @(negedge clk);
      if (load_seen != load_seq) begin
        cnt       = load_val;
        load_seen = load_seq;
      end
      if (ro_enable === 1'b1) begin
        ex = 0;
        if (!was_hi) begin
          ex = extra_tab[rise_cnt % 64];
          rise_cnt++;
        end
        cnt    = cnt + CNT_W'(1 + ex);
        was_hi = 1'b1;
      end else if (was_hi) begin
        was_hi = 1'b0;
        if (fall_cnt == inst_fall) inst_left = 10;
        cap_arr[fall_cnt % 64] = cnt ^ CNT_W'(inst_left > 0);
        fall_cnt++;
      end
      if (inst_left > 0) begin
        mask = ~mask;
        inst_left--;
      end else begin
        mask = 1'b0;
      end
      cnt_in = cnt ^ CNT_W'(mask);
    end
  end

  // Window-level reference: wrapping deltas between successive accepted captures.
  int               cap_rd = 0;
  logic [CNT_W-1:0] model_prev;
  logic [CNT_W-1:0] last_exp = '0;
  bit               err_at_start;

  function automatic logic [CNT_W-1:0] model_result();
    int               sum = 0;
    logic [CNT_W-1:0] v;
    logic [CNT_W-1:0] d;
    for (int w = 0; w < N; w++) begin
      v = cap_arr[cap_rd % 64];
      cap_rd++;
      d = v - model_prev;
      sum += int'(d);
      model_prev = v;
    end
    return CNT_W'(sum / N);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [CNT_W-1:0] v);
    load_val = v;
    load_seq++;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_extras(input int n, input bit rnd);
    for (int i = 0; i < n; i++)
      extra_tab[(rise_cnt + i) % 64] = rnd ? int'($urandom_range(0, 7)) : 0;
  endtask

  // One non-continuous measurement from IDLE; called just after a negedge.
  task automatic run_meas(input string tag, input int lat_exp, input int restart_k);
    int               lat = -1;
    int               hi = 0;
    bit               got = 1'b0;
    logic [CNT_W-1:0] exp;
    cap_rd     = fall_cnt;
    model_prev = cnt;
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        err_at_start = capture_err;
      end
      if (k == restart_k) start = 1'b1;
      if (k == restart_k + 1) start = 1'b0;
      if (ro_enable === 1'b1) hi++;
      if (result_valid === 1'b1) begin
        got = 1'b1;
        lat = k;
      end
    end
    check({tag, " valid_seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, lat, lat_exp);
    check({tag, " ro_enable_cycles"}, hi, N * G);
    exp = model_result();
    check({tag, " result"}, 32'(result), 32'(exp));
    last_exp = exp;
    @(negedge clk);
    check({tag, " valid_pulse"}, 32'(result_valid), 32'd0);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vt [3];
    int nv;
    bit seen;
    rst_n = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ro_enable", 32'(ro_enable), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset result_valid", 32'(result_valid), 32'd0);
    check("reset capture_err", 32'(capture_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic, then a second start while busy which must be ignored.
    preload('0);
    set_extras(N, 1'b0);
    run_meas("basic", LAT, -1);
    check("basic value", 32'(last_exp), 32'd10);
    set_extras(N, 1'b0);
    run_meas("start_while_busy", LAT, 20);

    // Counter wraps through 2**CNT_W during the first window.
    preload(15'h7FFA);
    set_extras(N, 1'b0);
    run_meas("wrap", LAT, -1);
    check("wrap first_capture", 32'(cap_arr[(fall_cnt - N) % 64]), 32'h0004);

    // Averaging with one long window: 10,10,10,11 truncates to 10.
    set_extras(N, 1'b0);
    extra_tab[(rise_cnt + 3) % 64] = 1;
    run_meas("avg", LAT, -1);
    check("avg value", 32'(last_exp), 32'd10);

    // Random preloads and random per-window extra counts.
    for (int i = 0; i < 4; i++) begin
      preload(CNT_W'($urandom));
      set_extras(N, 1'b1);
      run_meas($sformatf("rand%0d", i), LAT, -1);
    end

    // Unstable capture in the first window: forced accept after T tries.
    set_extras(N, 1'b1);
    inst_fall = fall_cnt;
    run_meas("unstable", LAT + T - 1, -1);
    check("unstable capture_err", 32'(capture_err), 32'd1);
    inst_fall = -1;
    set_extras(N, 1'b0);
    run_meas("after_unstable", LAT, -1);
    check("start clears capture_err", 32'(err_at_start), 32'd0);
    check("capture_err stays clear", 32'(capture_err), 32'd0);

    // Abort in the middle of the first gate window.
    set_extras(N, 1'b0);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
    end
    check("abort gate_active", 32'(ro_enable), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort ro_enable", 32'(ro_enable), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (result_valid === 1'b1) seen = 1'b1;
    end
    check("abort no_valid", 32'(seen), 32'd0);
    check("abort result_held", 32'(result), 32'(last_exp));

    // start and abort together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("start_abort busy", 32'(busy), 32'd0);

    // Continuous mode: back-to-back results reusing the previous capture.
    set_extras(4 * N, 1'b1);
    cap_rd     = fall_cnt;
    model_prev = cnt;
    continuous = 1'b1;
    start = 1'b1;
    nv = 0;
    @(posedge clk);
    for (int k = 0; k < 400 && nv < 3; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (result_valid === 1'b1) begin
        vt[nv] = k;
        nv++;
        check($sformatf("cont result%0d", nv), 32'(result), 32'(model_result()));
      end
    end
    check("cont count", nv, 3);
    check("cont first_latency", vt[0], LAT);
    check("cont spacing1", vt[1] - vt[0], PERIOD);
    check("cont spacing2", vt[2] - vt[1], PERIOD);

    // Reset while the gate is open.
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (ro_enable === 1'b1) seen = 1'b1;
    end
    check("cont gate_reached", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset ro_enable", 32'(ro_enable), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset result", 32'(result), 32'd0);
    check("midreset result_valid", 32'(result_valid), 32'd0);
    check("midreset capture_err", 32'(capture_err), 32'd0);
    continuous = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset busy", 32'(busy), 32'd0);
    for (int i = 0; i < 64; i++) extra_tab[i] = 0;
    run_meas("recover", LAT, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
